// File: rtl/brent_kung_sub_pipe.sv
// brent_kung_sub_pipe: recovers B = S - A from an adder result S, two-stage valid/ready pipeline.
// Stage s1 does the low half with a Brent-Kung borrow network; s2 finishes the upper half.
module brent_kung_sub_pipe #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_sum,
    input  logic [WIDTH-1:0] in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_b,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int H  = WIDTH / 2;
    localparam int HI = WIDTH - H;

    // Returns {carry_out, x - y}; subtraction is x + ~y + 1 with the +1 folded into bit 0.
    function automatic logic [H:0] bk_sub(input logic [H-1:0] x, input logic [H-1:0] y);
        logic [H-1:0] g, p, p0;
        p0 = x ^ ~y;
        p  = p0;
        g  = x & ~y;
        g[0] = g[0] | p[0];
        for (int d = 1; d < H; d = d * 2)
            for (int i = 2 * d - 1; i < H; i = i + 2 * d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        for (int d = 1 << ($clog2(H) - 1); d >= 1; d = d / 2)
            for (int i = 3 * d - 1; i < H; i = i + 2 * d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        return {g[H-1], p0 ^ {g[H-2:0], 1'b1}};
    endfunction

    logic             s1_valid_q, s1_valid_d, s1_bor_q, s1_bor_d;
    logic [H-1:0]     s1_lo_q, s1_lo_d;
    logic [HI:0]      s1_shi_q, s1_shi_d;
    logic [HI-1:0]    s1_ahi_q, s1_ahi_d;
    logic             s2_valid_q, s2_valid_d, s2_err_q, s2_err_d;
    logic [WIDTH-1:0] s2_b_q, s2_b_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             s1_en, s2_en;
    logic [H:0]       lo_res;
    logic [HI+1:0]    d_hi;

    assign s2_en     = !s2_valid_q | out_ready;
    assign s1_en     = !s1_valid_q | s2_en;
    assign in_ready  = s1_en & !rst;
    assign out_valid = s2_valid_q;
    assign out_b     = s2_b_q;
    assign out_err   = s2_err_q;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        lo_res     = bk_sub(in_sum[H-1:0], in_a[H-1:0]);
        d_hi       = {1'b0, s1_shi_q} - {2'b0, s1_ahi_q} - {{(HI+1){1'b0}}, s1_bor_q};
        s1_valid_d = s1_en ? in_valid : s1_valid_q;
        s1_lo_d    = (s1_en && in_valid) ? lo_res[H-1:0] : s1_lo_q;
        s1_bor_d   = (s1_en && in_valid) ? !lo_res[H] : s1_bor_q;
        s1_shi_d   = (s1_en && in_valid) ? in_sum[WIDTH:H] : s1_shi_q;
        s1_ahi_d   = (s1_en && in_valid) ? in_a[WIDTH-1:H] : s1_ahi_q;
        s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
        s2_b_d     = (s2_en && s1_valid_q) ? {d_hi[HI-1:0], s1_lo_q} : s2_b_q;
        // Negative (sign bit) or at least 2^WIDTH (bit HI) both mean B is out of range.
        s2_err_d   = (s2_en && s1_valid_q) ? (d_hi[HI+1] | d_hi[HI]) : s2_err_q;
        err_cnt_d  = (s2_valid_q && out_ready && s2_err_q && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_bor_q   <= 1'b0;
            s1_lo_q    <= '0;
            s1_shi_q   <= '0;
            s1_ahi_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_b_q     <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bor_q   <= s1_bor_d;
            s1_lo_q    <= s1_lo_d;
            s1_shi_q   <= s1_shi_d;
            s1_ahi_q   <= s1_ahi_d;
            s2_valid_q <= s2_valid_d;
            s2_err_q   <= s2_err_d;
            s2_b_q     <= s2_b_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// tb_brent_kung_sub_pipe: directed vectors plus a scoreboarded random stream for brent_kung_sub_pipe.
module tb_brent_kung_sub_pipe;
    localparam int W = 12;
    localparam int C = 8;
    localparam int NRND = 10000;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_err;
    logic [W:0] in_sum = '0;
    logic [W-1:0] in_a = '0, out_b;
    logic [C-1:0] err_cnt;
    int n_tests = 0, n_fail = 0, sent = 0, cyc = 0;
    int q_b[$];
    int q_e[$];

    always #5 clk = ~clk;

    brent_kung_sub_pipe #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_a(in_a),
        .out_valid(out_valid), .out_ready(out_ready), .out_b(out_b), .out_err(out_err), .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W:0] s, input logic [W-1:0] a);
        in_valid = v;
        in_sum = s;
        in_a = a;
        #1;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_b", out_b, 0);
        chk("rst_err", out_err, 0);
        chk("rst_cnt", err_cnt, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1, 13'h1000, 12'h001);
        chk("t1_ready", in_ready, 1);
        tick;
        drive(0, 0, 0);
        chk("t1_lat1", out_valid, 0);
        tick;
        chk("t1_valid", out_valid, 1);
        chk("t1_b", out_b, 12'hFFF);
        chk("t1_err", out_err, 0);
        tick;
        chk("t1_empty", out_valid, 0);
        chk("t1_cnt", err_cnt, 0);
        drive(1, 13'h0005, 12'h007);
        tick;
        drive(0, 0, 0);
        tick;
        chk("t2_b", out_b, 12'hFFE);
        chk("t2_err", out_err, 1);
        chk("t2_cnt0", err_cnt, 0);
        tick;
        chk("t2_cnt1", err_cnt, 1);
        drive(1, 13'h1FFF, 12'h000);
        tick;
        drive(0, 0, 0);
        tick;
        chk("t3_b", out_b, 12'hFFF);
        chk("t3_err", out_err, 1);
        tick;
        chk("t3_cnt", err_cnt, 2);
        out_ready = 1'b0;
        drive(1, 13'h0010, 12'h004);
        chk("t4_rdy0", in_ready, 1);
        tick;
        drive(1, 13'h0100, 12'h0FF);
        chk("t4_rdy1", in_ready, 1);
        tick;
        drive(1, 13'h1FFE, 12'hFFF);
        chk("t4_full", in_ready, 0);
        chk("t4_valid", out_valid, 1);
        chk("t4_b0", out_b, 12'h00C);
        tick;
        chk("t4_full2", in_ready, 0);
        chk("t4_stable", out_b, 12'h00C);
        tick;
        out_ready = 1'b1;
        #1;
        chk("t4_simul", in_ready, 1);
        chk("t4_o0", out_b, 12'h00C);
        chk("t4_e0", out_err, 0);
        tick;
        drive(0, 0, 0);
        chk("t4_o1", out_b, 12'h001);
        chk("t4_e1", out_err, 0);
        tick;
        chk("t4_o2", out_b, 12'hFFF);
        chk("t4_e2", out_err, 0);
        chk("t4_v2", out_valid, 1);
        tick;
        chk("t4_done", out_valid, 0);
        out_ready = 1'b0;
        drive(1, 13'h0005, 12'h007);
        tick;
        drive(1, 13'h0006, 12'h009);
        tick;
        drive(0, 0, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_cnt", err_cnt, 0);
        chk("t5_ready", in_ready, 1);
        out_ready = 1'b1;
        drive(1, 13'h0800, 12'h123);
        tick;
        drive(0, 0, 0);
        chk("t5_nostale", out_valid, 0);
        tick;
        chk("t5_v", out_valid, 1);
        chk("t5_b", out_b, 12'h6DD);
        chk("t5_e", out_err, 0);
        tick;
        chk("t5_empty", out_valid, 0);
        for (int i = 0; i < 300; i++) begin
            drive(1, 13'h0000, 12'h001);
            tick;
        end
        drive(0, 0, 0);
        repeat (3) tick;
        chk("t6_sat", err_cnt, 255);
        for (int i = 0; i < 5; i++) begin
            drive(1, 13'h0000, 12'h001);
            tick;
        end
        drive(0, 0, 0);
        repeat (3) tick;
        chk("t6_hold", err_cnt, 255);
        while ((sent < NRND || q_b.size() > 0) && cyc < 80000) begin
            in_valid = (sent < NRND) && ($urandom_range(3) != 0);
            in_sum = 13'($urandom_range(8191));
            in_a = 12'($urandom_range(4095));
            out_ready = $urandom_range(3) != 0;
            #1;
            if (out_valid && out_ready) begin
                if (q_b.size() == 0) chk("rnd_spurious", 1, 0);
                else begin
                    chk("rnd_b", out_b, q_b.pop_front());
                    chk("rnd_err", out_err, q_e.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                int d;
                d = int'(in_sum) - int'(in_a);
                q_b.push_back(d & 32'hFFF);
                q_e.push_back((d < 0 || d > 4095) ? 1 : 0);
                sent++;
            end
            tick;
            cyc++;
        end
        chk("rnd_sent", sent, NRND);
        chk("rnd_drain", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
